systolic_result_collector: RTL and testbench

Drain-side counterpart to the systolic operand feeder. The feeder skews A columns and B rows into the MAC array. This block accepts the skewed accumulator results shifted out of the array, one beat per cycle. It de-skews them into a flat row-major C matrix and presents C downstream with a valid/ready handshake.

---
 rtl/systolic_result_collector_pkg.sv | 33 +++
 rtl/collector_row_lane.sv | 66 ++++++
 rtl/systolic_result_collector.sv | 124 ++++++++++++
 tb/tb_systolic_result_collector.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// systolic_result_collector_pkg
//
// Purpose:
//   Shared definitions for the systolic result collector. The package holds:
//     - the collector FSM state encoding;
//     - the row-major flat index helper, which matches the indexing the
//       operand feeder uses for A and B;
//     - the last-beat helper. An N x N array drains its results over
//       2N-1 skewed beats, numbered 0..2N-2.
//
// Ports:
//   (package, no ports)
// ---------------------------------------------------------------------------
package systolic_result_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } collector_state_t;

    // Row-major flat position of element [row][col] in an n x n matrix.
    function automatic int flat_index(input int row, input int col, input int n);
        return row * n + col;
    endfunction

    // Number of the final drain beat for an n x n array.
    function automatic int last_beat(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/collector_row_lane.sv
// ---------------------------------------------------------------------------
// collector_row_lane
//
// Purpose:
//   Holds the N result registers of one C row (row ROW). On drain beat k,
//   the value leaving array row ROW belongs to column k-ROW. The lane writes
//   it only when that column is in 0..N-1. The skewed head and tail beats
//   fall outside that range and the lane drops them.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   clear      in   zero all registers of this row (new matrix armed)
//   write_en   in   a drain beat is being accepted this cycle
//   beat       in   current beat number k
//   lane_data  in   value leaving array row ROW on this beat
//   row_data   out  C[ROW][0..N-1], column c at bits c*ACC_WIDTH
// ---------------------------------------------------------------------------
module collector_row_lane #(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_W     = 9,
    parameter int ROW       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   write_en,
    input  logic [CNT_W-1:0]       beat,
    input  logic [ACC_WIDTH-1:0]   lane_data,
    output logic [N*ACC_WIDTH-1:0] row_data
);

    // Column arithmetic uses one extra bit. A beat earlier than ROW then
    // gives a negative column, and the lane rejects it. It does not wrap
    // around to a large positive column.
    localparam int CW = CNT_W + 1;

    logic signed [CW-1:0]  col_s;
    logic [CNT_W-1:0]      col_idx;
    logic                  in_range;
    logic [ACC_WIDTH-1:0]  row_regs [N];

    assign col_s    = $signed({1'b0, beat}) - $signed(CW'(ROW));
    assign col_idx  = col_s[CW-2:0];
    assign in_range = !col_s[CW-1] && (col_idx < CNT_W'(N));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_regs <= '{default: '0};
        end else if (clear) begin
            row_regs <= '{default: '0};
        end else begin
            for (int c = 0; c < N; c++) begin
                if (write_en && in_range && (col_idx == CNT_W'(c))) begin
                    row_regs[c] <= lane_data;
                end
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_col
        assign row_data[c*ACC_WIDTH +: ACC_WIDTH] = row_regs[c];
    end

endmodule

// File: rtl/systolic_result_collector.sv
// ---------------------------------------------------------------------------
// systolic_result_collector
//
// Purpose:
//   Drain-side counterpart to the systolic operand feeder. The block accepts
//   the skewed accumulator beats shifted out of the MAC array and de-skews
//   them into a flat row-major C matrix. It holds C for downstream under a
//   valid/ready handshake.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle pulse, arms collection (honoured in IDLE only)
//   drain_valid  in   drain_data carries a beat this cycle
//   drain_data   in   slice i = value leaving array row i
//   busy         out  high in COLLECT or HOLD
//   c_valid      out  C complete and held
//   c_ready      in   downstream accepts C
//   c_data       out  C[r][c] at bits ACC_WIDTH*(r*N+c)
//   overrun      out  sticky: a drain beat arrived while C was being held
// ---------------------------------------------------------------------------
module systolic_result_collector
    import systolic_result_collector_pkg::*;
#(
    parameter int N          = 2,
    parameter int ACC_WIDTH  = 32,
    parameter int LOG2_MAX_N = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     drain_valid,
    input  logic [N*ACC_WIDTH-1:0]   drain_data,
    output logic                     busy,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic [N*N*ACC_WIDTH-1:0] c_data,
    output logic                     overrun
);

    localparam int CNT_W = LOG2_MAX_N + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(last_beat(N));

    collector_state_t state;
    logic [CNT_W-1:0] beat;
    logic             lane_clear;
    logic             lane_write;

    // The lanes follow the FSM. A start accepted in IDLE wipes the previous
    // matrix. Beats count only while collecting, so beats that arrive in
    // IDLE or HOLD never reach the result registers.
    assign lane_clear = (state == ST_IDLE) && start;
    assign lane_write = (state == ST_COLLECT) && drain_valid;

    // Control FSM. busy and c_valid are registered with the state, so they
    // change on the same edge as the state transition. HOLD therefore lasts
    // at least one cycle even when c_ready is already high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            beat    <= '0;
            busy    <= 1'b0;
            c_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_COLLECT;
                        beat    <= '0;
                        busy    <= 1'b1;
                        overrun <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (drain_valid) begin
                        beat <= beat + CNT_W'(1);
                        if (beat == LAST_BEAT) begin
                            state   <= ST_HOLD;
                            c_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (drain_valid) begin
                        overrun <= 1'b1;
                    end
                    if (c_valid && c_ready) begin
                        state   <= ST_IDLE;
                        c_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    c_valid <= 1'b0;
                end
            endcase
        end
    end

    // One lane per row. The lane for row i writes the contiguous slice of
    // c_data that starts at element [i][0].
    for (genvar i = 0; i < N; i++) begin : g_row
        localparam int BASE = flat_index(i, 0, N) * ACC_WIDTH;

        collector_row_lane #(
            .N         (N),
            .ACC_WIDTH (ACC_WIDTH),
            .CNT_W     (CNT_W),
            .ROW       (i)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clear     (lane_clear),
            .write_en  (lane_write),
            .beat      (beat),
            .lane_data (drain_data[i*ACC_WIDTH +: ACC_WIDTH]),
            .row_data  (c_data[BASE +: N*ACC_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// ---------------------------------------------------------------------------
// tb_systolic_result_collector
//
// Purpose:
//   Directed testbench. It instantiates one N=2 collector and one N=3
//   collector. The N=2 collector runs a table of per-cycle vectors, then
//   hand-written stall and reset sequences. The N=3 collector runs a skewed
//   10*r+c matrix with c_ready tied high.
// ---------------------------------------------------------------------------
module tb_systolic_result_collector;

    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic            start2, dv2, cr2, busy2, cv2, ov2;
    logic [2*AW-1:0] dd2;
    logic [4*AW-1:0] cd2;

    logic            start3, dv3, cr3, busy3, cv3, ov3;
    logic [3*AW-1:0] dd3;
    logic [9*AW-1:0] cd3;

    int total = 0;
    int bad   = 0;

    systolic_result_collector #(.N(2), .ACC_WIDTH(AW), .LOG2_MAX_N(8)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .start       (start2),
        .drain_valid (dv2),
        .drain_data  (dd2),
        .busy        (busy2),
        .c_valid     (cv2),
        .c_ready     (cr2),
        .c_data      (cd2),
        .overrun     (ov2)
    );

    systolic_result_collector #(.N(3), .ACC_WIDTH(AW), .LOG2_MAX_N(8)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .start       (start3),
        .drain_valid (dv3),
        .drain_data  (dd3),
        .busy        (busy3),
        .c_valid     (cv3),
        .c_ready     (cr3),
        .c_data      (cd3),
        .overrun     (ov3)
    );

    // One per-cycle vector for the N=2 collector: the inputs for the cycle,
    // then the outputs expected just after the clock edge.
    typedef struct {
        logic        start;
        logic        dv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        cr;
        logic        busy;
        logic        cv;
        logic        ov;
        logic [31:0] c00;
        logic [31:0] c01;
        logic [31:0] c10;
        logic [31:0] c11;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic st, input logic dv, input logic [31:0] d0,
                                input logic [31:0] d1, input logic cr, input logic b,
                                input logic cv, input logic ov, input logic [31:0] c00,
                                input logic [31:0] c01, input logic [31:0] c10,
                                input logic [31:0] c11);
        vec_t v;
        v.start = st; v.dv = dv; v.d0 = d0; v.d1 = d1; v.cr = cr;
        v.busy = b; v.cv = cv; v.ov = ov;
        v.c00 = c00; v.c01 = c01; v.c10 = c10; v.c11 = c11;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act,
                               input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the N=2 inputs on the falling edge, then let one rising edge
    // pass. Outputs are sampled 1 time unit after that edge.
    task automatic drive2(input logic st, input logic dv, input logic [31:0] d0,
                          input logic [31:0] d1, input logic cr);
        @(negedge clk);
        start2 = st; dv2 = dv; dd2 = {d1, d0}; cr2 = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic st, input logic dv, input logic [3*AW-1:0] d);
        @(negedge clk);
        start3 = st; dv3 = dv; dd3 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive2(v.start, v.dv, v.d0, v.d1, v.cr);
    endtask

    initial begin
        logic [9*AW-1:0] exp3;
        logic [3*AW-1:0] beat3;
        int              cv_high;
        logic [31:0]     sd0 [3];
        logic [31:0]     sd1 [3];

        reset = 1'b0;
        start2 = 0; dv2 = 0; dd2 = '0; cr2 = 0;
        start3 = 0; dv3 = 0; dd3 = '0; cr3 = 1;

        // Normal collect, backpressure with start/overrun, second collect,
        // a start coinciding with the handshake, and a drain beat in IDLE.
        vecs[0]  = mk(1, 0, 0,     0,     0, 1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 5,     99,    0, 1, 0, 0, 5, 0, 0, 0);
        vecs[2]  = mk(0, 1, 6,     7,     0, 1, 0, 0, 5, 6, 7, 0);
        vecs[3]  = mk(0, 1, 77,    8,     0, 1, 1, 0, 5, 6, 7, 8);
        vecs[4]  = mk(1, 1, 'hAA,  'hAA,  0, 1, 1, 1, 5, 6, 7, 8);
        vecs[5]  = mk(1, 1, 'hAA,  'hAA,  0, 1, 1, 1, 5, 6, 7, 8);
        vecs[6]  = mk(1, 1, 'hAA,  'hAA,  0, 1, 1, 1, 5, 6, 7, 8);
        vecs[7]  = mk(1, 1, 'hAA,  'hAA,  0, 1, 1, 1, 5, 6, 7, 8);
        vecs[8]  = mk(1, 1, 'hAA,  'hAA,  0, 1, 1, 1, 5, 6, 7, 8);
        vecs[9]  = mk(0, 0, 0,     0,     1, 0, 0, 1, 5, 6, 7, 8);
        vecs[10] = mk(0, 0, 0,     0,     0, 0, 0, 1, 5, 6, 7, 8);
        vecs[11] = mk(1, 0, 0,     0,     0, 1, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 1,     0,     0, 1, 0, 0, 1, 0, 0, 0);
        vecs[13] = mk(0, 1, 2,     3,     0, 1, 0, 0, 1, 2, 3, 0);
        vecs[14] = mk(0, 1, 0,     4,     0, 1, 1, 0, 1, 2, 3, 4);
        vecs[15] = mk(1, 0, 0,     0,     1, 0, 0, 0, 1, 2, 3, 4);
        vecs[16] = mk(0, 1, 'h55,  'h55,  0, 0, 0, 0, 1, 2, 3, 4);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",   512'(busy2), 512'(0));
        checkOutput("rst_cvalid", 512'(cv2),   512'(0));
        checkOutput("rst_ovr",    512'(ov2),   512'(0));
        checkOutput("rst_cdata",  512'(cd2),   512'(0));
        checkOutput("rst_cdata3", 512'(cd3),   512'(0));
        @(negedge clk);
        reset = 1'b1;

        // Table-driven N=2 sequence
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_busy", i),  512'(busy2), 512'(vecs[i].busy));
            checkOutput($sformatf("v%0d_cvalid", i), 512'(cv2),  512'(vecs[i].cv));
            checkOutput($sformatf("v%0d_ovr", i),   512'(ov2),   512'(vecs[i].ov));
            checkOutput($sformatf("v%0d_cdata", i), 512'(cd2),
                        512'({vecs[i].c11, vecs[i].c10, vecs[i].c01, vecs[i].c00}));
        end

        // Stalls: the same data with two idle cycles after every beat
        sd0[0] = 5;  sd0[1] = 6; sd0[2] = 77;
        sd1[0] = 99; sd1[1] = 7; sd1[2] = 8;
        drive2(1, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            drive2(0, 1, sd0[b], sd1[b], 0);
            checkOutput($sformatf("stall_b%0d_cvalid", b), 512'(cv2), 512'(b == 2));
            if (b < 2) begin
                repeat (2) drive2(0, 0, 'hDEAD, 'hBEEF, 0);
                checkOutput($sformatf("stall_gap%0d_cvalid", b), 512'(cv2), 512'(0));
            end
        end
        checkOutput("stall_cdata", 512'(cd2), 512'({32'd8, 32'd7, 32'd6, 32'd5}));
        drive2(0, 0, 0, 0, 1);
        checkOutput("stall_idle_busy", 512'(busy2), 512'(0));

        // Reset mid-collect, then a clean collect afterwards
        drive2(1, 0, 0, 0, 0);
        drive2(0, 1, 5, 99, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy",   512'(busy2), 512'(0));
        checkOutput("midrst_cvalid", 512'(cv2),   512'(0));
        checkOutput("midrst_ovr",    512'(ov2),   512'(0));
        checkOutput("midrst_cdata",  512'(cd2),   512'(0));
        @(negedge clk);
        reset = 1'b1;
        drive2(1, 0, 0, 0, 0);
        drive2(0, 1, 9, 1234, 0);
        drive2(0, 1, 10, 11, 0);
        drive2(0, 1, 4321, 12, 0);
        checkOutput("postrst_cvalid", 512'(cv2), 512'(1));
        checkOutput("postrst_cdata",  512'(cd2), 512'({32'd12, 32'd11, 32'd10, 32'd9}));
        drive2(0, 0, 0, 0, 1);

        // N=3: C[r][c] = 10r+c, skewed over 5 beats, c_ready tied high
        exp3 = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp3[(r*3+c)*AW +: AW] = AW'(10*r + c);
        cv_high = 0;
        drive3(1, 0, '0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (k - i >= 0 && k - i < 3) beat3[i*AW +: AW] = AW'(10*i + (k - i));
                else                         beat3[i*AW +: AW] = AW'(999);
            end
            drive3(0, 1, beat3);
            if (cv3) cv_high++;
        end
        checkOutput("n3_latency", 512'(cv3), 512'(1));
        checkOutput("n3_cdata",   512'(cd3), 512'(exp3));
        for (int j = 0; j < 5; j++) begin
            drive3(0, 0, '0);
            if (cv3) cv_high++;
        end
        checkOutput("n3_cvalid_cycles", 512'(cv_high), 512'(1));
        checkOutput("n3_idle_busy",     512'(busy3),   512'(0));
        checkOutput("n3_cdata_kept",    512'(cd3),     512'(exp3));
        checkOutput("n3_ovr",           512'(ov3),     512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
